// File: rtl/soc_system_mem_arb_pkg.sv
// soc_system_mem_arb_pkg: shared types, response codes and default sizing for the on-chip memory arbiter
package soc_system_mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF = 12500;
  localparam int MAX_HOLD_DEF = 4;
endpackage

// File: rtl/soc_system_mem_arb_grant.sv
// soc_system_mem_arb_grant: two-requester grant FSM with bounded hold under contention
module soc_system_mem_arb_grant
  import soc_system_mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  localparam int HW = $clog2(MAX_HOLD + 2);
  arb_state_t state, state_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic last_grant, last_grant_d, pick1, any, both, cap;
  always_comb begin
    both = req0 & req1;
    cap = hold_cnt == HW'(MAX_HOLD);
    any = (req0 | req1) & reset_n;
    // contention in OWNn flips to the other requester exactly when the hold cap is reached
    pick1 = state == IDLE ? req1 & (!req0 | !last_grant) : both ? ((state == OWN1) ^ cap) : req1;
    gnt0 = any & !pick1;
    gnt1 = any & pick1;
    state_d = !(req0 | req1) ? IDLE : pick1 ? OWN1 : OWN0;
    hold_d = (state != IDLE && both && !cap) ? hold_cnt + 1'b1 : '0;
    last_grant_d = any ? pick1 : last_grant;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      hold_cnt <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_d;
      hold_cnt <= hold_d;
      last_grant <= last_grant_d;
    end
  end
endmodule

// File: rtl/soc_system_onchip_mem_arbiter.sv
// soc_system_onchip_mem_arbiter: arbitrates two requesters onto one single-port RAM
module soc_system_onchip_mem_arbiter
  import soc_system_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  output logic [1:0]          m0_response,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [1:0]          m1_response,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  logic gnt0, gnt1, gnt, wr, in_range, rd_gnt;
  logic rv_valid, rv_owner, rv_err;
  logic [DATA_W-1:0] rdata;
  soc_system_mem_arb_grant #(.MAX_HOLD(MAX_HOLD)) u_grant (
    .clk(clk), .reset_n(reset_n),
    .req0(m0_read | m0_write), .req1(m1_read | m1_write),
    .gnt0(gnt0), .gnt1(gnt1)
  );
  always_comb begin
    gnt = gnt0 | gnt1;
    mem_address = gnt1 ? m1_address : m0_address;
    mem_writedata = gnt1 ? m1_writedata : m0_writedata;
    wr = gnt1 ? m1_write : m0_write;
    in_range = {1'b0, mem_address} < (ADDR_W + 1)'(DEPTH);
    // out-of-range accesses are still granted but never reach the RAM
    mem_chipselect = gnt & in_range;
    mem_write = mem_chipselect & wr;
    mem_byteenable = gnt ? (gnt1 ? m1_byteenable : m0_byteenable) : '0;
    mem_clken = reset_n;
    rd_gnt = gnt & !wr;
    m0_waitrequest = !gnt0;
    m1_waitrequest = !gnt1;
    rdata = rv_err ? '0 : mem_readdata;
    m0_readdata = rdata;
    m1_readdata = rdata;
    m0_readdatavalid = rv_valid & !rv_owner;
    m1_readdatavalid = rv_valid & rv_owner;
    m0_response = (m0_readdatavalid & rv_err) ? RESP_SLVERR : RESP_OKAY;
    m1_response = (m1_readdatavalid & rv_err) ? RESP_SLVERR : RESP_OKAY;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv_valid <= 1'b0;
      rv_owner <= 1'b0;
      rv_err <= 1'b0;
    end else begin
      rv_valid <= rd_gnt;
      rv_owner <= gnt1;
      rv_err <= !in_range;
    end
  end
endmodule

// File: tb/tb_soc_system_onchip_mem_arbiter.sv
// tb_soc_system_onchip_mem_arbiter: directed vectors against a behavioural RAM with hand-computed expectations
module tb_soc_system_onchip_mem_arbiter;
  logic clk = 1'b0, reset_n;
  logic [13:0] m0_address, m1_address, mem_address;
  logic [7:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [63:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, mem_writedata, mem_readdata;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [1:0] m0_response, m1_response;
  logic mem_chipselect, mem_write, mem_clken;
  logic [63:0] ram [0:16383];
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  soc_system_onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid), .m0_response(m0_response),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid), .m1_response(m1_response),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );
  always @(posedge clk) begin
    if (mem_chipselect && mem_write)
      for (int b = 0; b < 8; b++)
        if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    mem_readdata <= (mem_chipselect && !mem_write) ? ram[mem_address] : 64'hBADB_ADBA_DBAD_BADB;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int exp_own, prev;
    for (int i = 0; i < 16384; i++) ram[i] = 64'h0;
    ram[1] = 64'h1111_1111_1111_1111;
    ram[2] = 64'h2222_2222_2222_2222;
    ram[16] = 64'h0123_4567_89AB_CDEF;
    ram[12500] = 64'h5555_5555_5555_5555;
    reset_n = 1'b0;
    {m0_read, m0_write, m1_read, m1_write} = '0;
    m0_address = 14'd1; m1_address = 14'd2;
    m0_byteenable = 8'hFF; m1_byteenable = 8'hFF;
    m0_writedata = '0; m1_writedata = '0;
    m0_read = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_w0", m0_waitrequest, 1);
    check("rst_w1", m1_waitrequest, 1);
    check("rst_cs", mem_chipselect, 0);
    check("rst_wr", mem_write, 0);
    check("rst_clken", mem_clken, 0);
    check("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    check("rst_resp", {m0_response, m1_response}, 0);
    step;
    reset_n = 1'b1;
    m1_read = 1'b1;
    prev = -1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      exp_own = (i / 5) % 2;
      check("cont_w0", m0_waitrequest, exp_own == 1);
      check("cont_w1", m1_waitrequest, exp_own == 0);
      if (i > 0) begin
        check("cont_rdv0", m0_readdatavalid, prev == 0);
        check("cont_rdv1", m1_readdatavalid, prev == 1);
        check("cont_data", prev == 0 ? m0_readdata : m1_readdata, prev == 0 ? 64'h1111_1111_1111_1111 : 64'h2222_2222_2222_2222);
      end
      prev = exp_own;
      step;
    end
    m0_read = 1'b0; m1_read = 1'b0;
    @(negedge clk);
    check("cont_last_rdv0", m0_readdatavalid, 1);
    check("cont_last_rdv1", m1_readdatavalid, 0);
    check("clken", mem_clken, 1);
    step;
    m0_read = 1'b1; m0_address = 14'h0010;
    @(negedge clk);
    check("rd_w0", m0_waitrequest, 0);
    check("rd_w1", m1_waitrequest, 1);
    check("rd_cs", mem_chipselect, 1);
    check("rd_wr", mem_write, 0);
    check("rd_addr", mem_address, 14'h0010);
    step;
    m0_read = 1'b0;
    @(negedge clk);
    check("rd_rdv0", m0_readdatavalid, 1);
    check("rd_data", m0_readdata, 64'h0123_4567_89AB_CDEF);
    check("rd_resp", m0_response, 2'b00);
    check("rd_rdv1", m1_readdatavalid, 0);
    check("rd_idle_cs", mem_chipselect, 0);
    check("rd_idle_be", mem_byteenable, 0);
    step;
    check("rd_once", m0_readdatavalid, 0);
    m1_write = 1'b1; m1_address = 14'd5; m1_writedata = 64'hFFFF_FFFF_FFFF_FFFF; m1_byteenable = 8'h0F;
    @(negedge clk);
    check("bw_w1", m1_waitrequest, 0);
    check("bw_cs", mem_chipselect, 1);
    check("bw_wr", mem_write, 1);
    check("bw_be", mem_byteenable, 8'h0F);
    step;
    m1_write = 1'b0; m1_read = 1'b1;
    @(negedge clk);
    check("bw_no_rdv", m1_readdatavalid, 0);
    step;
    m1_read = 1'b0;
    @(negedge clk);
    check("bw_rdv1", m1_readdatavalid, 1);
    check("bw_data", m1_readdata, 64'h0000_0000_FFFF_FFFF);
    step;
    m0_write = 1'b1; m0_address = 14'd12500; m0_writedata = 64'hCAFE_CAFE_CAFE_CAFE;
    @(negedge clk);
    check("oor_wr_w0", m0_waitrequest, 0);
    check("oor_wr_cs", mem_chipselect, 0);
    check("oor_wr_wr", mem_write, 0);
    step;
    m0_write = 1'b0; m0_read = 1'b1;
    @(negedge clk);
    check("oor_rd_w0", m0_waitrequest, 0);
    check("oor_rd_cs", mem_chipselect, 0);
    step;
    m0_read = 1'b0;
    @(negedge clk);
    check("oor_rdv0", m0_readdatavalid, 1);
    check("oor_data", m0_readdata, 0);
    check("oor_resp", m0_response, 2'b10);
    check("oor_ram", ram[12500], 64'h5555_5555_5555_5555);
    step;
    m0_read = 1'b1; m0_address = 14'd1;
    repeat (3) step;
    m0_read = 1'b0; m1_read = 1'b1; m1_address = 14'd2;
    @(negedge clk);
    check("ho_w1", m1_waitrequest, 0);
    check("ho_w0", m0_waitrequest, 1);
    check("ho_rdv0", m0_readdatavalid, 1);
    for (int i = 0; i < 7; i++) begin
      step;
      @(negedge clk);
      check("solo_w1", m1_waitrequest, 0);
    end
    step;
    m1_read = 1'b0; m0_read = 1'b1; m0_address = 14'h0010;
    @(negedge clk);
    check("mr_w0", m0_waitrequest, 0);
    step;
    m0_read = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    check("mr_rdv0", m0_readdatavalid, 0);
    check("mr_w0_rst", m0_waitrequest, 1);
    check("mr_clken", mem_clken, 0);
    step;
    reset_n = 1'b1; m1_read = 1'b1; m1_address = 14'd5;
    @(negedge clk);
    check("mr_w1", m1_waitrequest, 0);
    check("mr_rdv0_after", m0_readdatavalid, 0);
    step;
    m1_read = 1'b0;
    @(negedge clk);
    check("mr_rdv1", m1_readdatavalid, 1);
    check("mr_data", m1_readdata, 64'h0000_0000_FFFF_FFFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
